// File: rtl/operators_responder.sv
// operators_responder: one-request-at-a-time operator unit.
// A request is latched in IDLE, evaluated during a single EXEC cycle and then
// offered in RESP until the consumer takes it. Counters track completed and
// illegal-op responses.
module operators_responder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] op,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] result,
    output logic       err,
    output logic [7:0] txn_count,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_in_ready;
    logic       r_out_valid;
    logic [3:0] r_op;
    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_c;
    logic [3:0] r_d;
    logic [3:0] r_result;
    logic       r_err;
    logic [7:0] r_txn_count;
    logic [7:0] r_err_count;

    logic [3:0] w_result;
    logic       w_err;

    // Operator evaluation from the latched operands; only sampled in EXEC.
    always_comb begin
        w_result = 4'd0;
        w_err    = 1'b0;
        case (r_op)
            4'd0: w_result = r_a + r_b;
            4'd1: w_result = (r_c >= 4'd4) ? 4'd0 : (r_a << r_c[1:0]);
            4'd2: w_result = {3'b000, (r_a > r_b)};
            4'd3: w_result = {3'b000, (r_a == r_d)};
            4'd4: w_result = r_a & r_b;
            4'd5: w_result = {3'b000, ^r_a};
            4'd6: w_result = {3'b000, ((r_a != 4'd0) && (r_b != 4'd0))};
            4'd7: w_result = {r_a[1:0], r_b[1:0]};
            4'd8: w_result = (r_c != 4'd0) ? r_a : r_b;
            default: begin
                w_result = 4'd0;
                w_err    = 1'b1;
            end
        endcase
    end

    // Control FSM with registered handshake outputs, result holding and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_op        <= 4'd0;
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_c         <= 4'd0;
            r_d         <= 4'd0;
            r_result    <= 4'd0;
            r_err       <= 1'b0;
            r_txn_count <= 8'd0;
            r_err_count <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_a        <= A;
                        r_b        <= B;
                        r_c        <= C;
                        r_d        <= D;
                        r_in_ready <= 1'b0;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    r_result    <= w_result;
                    r_err       <= w_err;
                    r_out_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    // Result/err stay untouched here so they persist after the handshake.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_txn_count <= r_txn_count + 8'd1;
                        if (r_err && (r_err_count != 8'hFF)) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign err       = r_err;
    assign txn_count = r_txn_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_operators_responder.sv
// Testbench for operators_responder: transaction-level reference model with a
// per-cycle comparator, plus directed literal expectations.
module tb_operators_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] op = 4'd0;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic [3:0] C = 4'd0;
    logic [3:0] D = 4'd0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] result;
    logic       err;
    logic [7:0] txn_count;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    operators_responder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .A(A), .B(B), .C(C), .D(D),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .err(err), .txn_count(txn_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference operator: bit 4 carries the illegal-op flag, bits 3:0 the result.
    function automatic int ref_op(input int o, input int a, input int b, input int c, input int d);
        int ones;
        case (o)
            0: return (a + b) % 16;
            1: return (c >= 4) ? 0 : (a * (1 << c)) % 16;
            2: return (a > b) ? 1 : 0;
            3: return (a == d) ? 1 : 0;
            4: return a & b;
            5: begin
                ones = 0;
                for (int k = 0; k < 4; k++) ones += (a >> k) % 2;
                return ones % 2;
            end
            6: return (a != 0 && b != 0) ? 1 : 0;
            7: return (a % 4) * 4 + (b % 4);
            8: return (c != 0) ? a : b;
            default: return 16;
        endcase
    endfunction

    // Transaction-level model: remembers accept edge, evaluates one edge later,
    // retires on the first later edge with out_ready.
    int edge_k = 0;
    bit m_busy = 1'b0;
    int m_acc = 0;
    int m_op, m_a, m_b, m_c, m_d;
    int m_result = 0, m_err = 0, m_txn = 0, m_errc = 0;
    int tmp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_result = 0; m_err = 0; m_txn = 0; m_errc = 0;
            m_op = 0; m_a = 0; m_b = 0; m_c = 0; m_d = 0;
        end else begin
            edge_k++;
            if (!m_busy) begin
                if (in_valid) begin
                    m_op = int'(op); m_a = int'(A); m_b = int'(B); m_c = int'(C); m_d = int'(D);
                    m_busy = 1'b1;
                    m_acc = edge_k;
                end
            end else if (edge_k == m_acc + 1) begin
                tmp = ref_op(m_op, m_a, m_b, m_c, m_d);
                m_result = tmp % 16;
                m_err = tmp / 16;
            end else if (out_ready) begin
                m_txn = (m_txn + 1) % 256;
                if (m_err != 0) m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                m_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", int'(in_ready), m_busy ? 0 : 1);
            check("out_valid", int'(out_valid), (m_busy && edge_k >= m_acc + 1) ? 1 : 0);
            check("result", int'(result), m_result);
            check("err", int'(err), m_err);
            check("txn_count", int'(txn_count), m_txn);
            check("err_count", int'(err_count), m_errc);
        end
    end

    task automatic run_txn(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d, input int stall,
                           input bit pin, output int res, output int e);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; op = o; A = a; B = b; C = c; D = d;
        out_ready = 1'($urandom);
        @(posedge clk); #1;
        in_valid = 1'($urandom); op = 4'($urandom);
        A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
        n = 0;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_timeout", int'(out_valid), 1);
        res = int'(result);
        e = int'(err);
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            in_valid = 1'($urandom); op = 4'($urandom);
            A = 4'($urandom); B = 4'($urandom); C = 4'($urandom); D = 4'($urandom);
            @(posedge clk); #1;
            if (pin) begin
                check("bp_out_valid", int'(out_valid), 1);
                check("bp_result", int'(result), res);
                check("bp_in_ready", int'(in_ready), 0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        if (pin) check("bp_released_in_ready", int'(in_ready), 1);
    endtask

    int exp26 [9] = '{2, 0, 1, 1, 4, 0, 1, 2, 12};
    int r, e, base;

    initial begin
        // Reset: asserted between edges, state must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_err", int'(err), 0);
        check("rst_txn", int'(txn_count), 0);
        check("rst_errc", int'(err_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // All legal ops with the reference operand set.
        for (int i = 0; i < 9; i++) begin
            run_txn(4'(i), 4'hC, 4'h6, 4'h2, 4'hC, 0, 1'b0, r, e);
            check($sformatf("op%0d_result", i), r, exp26[i]);
            check($sformatf("op%0d_err", i), e, 0);
        end
        check("txn_after_9", int'(txn_count), 9);

        // Backpressure with input noise while the response is held.
        run_txn(4'd0, 4'hC, 4'h6, 4'h2, 4'hC, 5, 1'b1, r, e);
        check("bp_final_result", r, 2);
        check("txn_after_bp", int'(txn_count), 10);

        // Illegal ops.
        run_txn(4'd9, 4'hC, 4'h6, 4'h2, 4'hC, 0, 1'b0, r, e);
        check("op9_result", r, 0);
        check("op9_err", e, 1);
        run_txn(4'd15, 4'h3, 4'h7, 4'h1, 4'h2, 1, 1'b0, r, e);
        check("op15_result", r, 0);
        check("op15_err", e, 1);
        check("errc_after_illegal", int'(err_count), 2);
        check("txn_after_illegal", int'(txn_count), 12);

        // Operand boundaries.
        run_txn(4'd0, 4'hF, 4'h1, 4'h0, 4'h0, 0, 1'b0, r, e);
        check("add_wrap", r, 0);
        run_txn(4'd1, 4'h3, 4'h0, 4'h4, 4'h0, 0, 1'b0, r, e);
        check("shift_c4", r, 0);
        run_txn(4'd8, 4'h9, 4'h5, 4'h0, 4'h0, 0, 1'b0, r, e);
        check("sel_c0", r, 5);

        // Reset during RESP.
        @(posedge clk); #1;
        in_valid = 1'b1; op = 4'd4; A = 4'hC; B = 4'h6; C = 4'h2; D = 4'hC; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_out_valid_before", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_txn", int'(txn_count), 0);
        check("mid_rst_errc", int'(err_count), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_txn(4'd4, 4'hC, 4'h6, 4'h2, 4'hC, 0, 1'b0, r, e);
        check("after_rst_result", r, 4);
        check("after_rst_txn", int'(txn_count), 1);

        // Counter wrap and saturation.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++)
            run_txn(4'($urandom_range(9, 15)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0, 1'b0, r, e);
        check("txn_wrap_256", int'(txn_count), 0);
        check("errc_at_256", int'(err_count), 255);
        for (int i = 0; i < 4; i++)
            run_txn(4'($urandom_range(9, 15)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 0, 1'b0, r, e);
        check("errc_sat_260", int'(err_count), 255);
        check("txn_after_260", int'(txn_count), 4);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 200; i++) begin
            logic [3:0] ro, ra, rb, rc, rd;
            ro = 4'($urandom_range(0, 15)); ra = 4'($urandom); rb = 4'($urandom);
            rc = 4'($urandom); rd = 4'($urandom);
            run_txn(ro, ra, rb, rc, rd, int'($urandom_range(0, 3)), 1'b0, r, e);
            base = ref_op(int'(ro), int'(ra), int'(rb), int'(rc), int'(rd));
            check("rand_result", r, base % 16);
            check("rand_err", e, base / 16);
        end

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/operators_responder.md
OPERATORS_RESPONDER -- requirements
Module: operators_responder

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: in_valid  input  1  request offered.
REQ-005 Port: in_ready  output  1  responder can accept a request.
REQ-006 Port: op  input  4  operator select (encoding in REQ-016).
REQ-007 Port: A, B, C, D  input  4 each  operands.
REQ-008 Port: out_valid  output  1  result offered.
REQ-009 Port: out_ready  input  1  consumer takes the result.
REQ-010 Port: result  output  4  operator result.
REQ-011 Port: err  output  1  the current result came from an illegal op.
REQ-012 Port: txn_count  output  8  completed responses, wrapping mod 256.
REQ-013 Port: err_count  output  8  illegal-op responses, saturating at 255.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP, with a 2-bit state register.
- IDLE: in_ready=1.
- in_valid=1 in IDLE: on that edge, register op/A/B/C/D and go to EXEC.
REQ-015 EXEC SHALL last exactly one cycle.
- In EXEC, compute result/err from the registered operands into output registers.
- Go to RESP.
REQ-016 Op encoding, with all arithmetic mod 16 and 1-bit results zero-extended:
- 0: A+B, carry dropped.
- 1: A<<C; result is 0000 for C>=4.
- 2: A>B.
- 3: A==D.
- 4: A&B.
- 5: ^A (reduction XOR).
- 6: (A!=0)&&(B!=0).
- 7: {A[1:0],B[1:0]}.
- 8: (C!=0)?A:B.
- 9-15: result=0000, err=1.
REQ-017 In RESP, out_valid SHALL be 1 and result/err SHALL be held stable until out_ready=1.
- The response handshake completes on an edge where out_valid=1 and out_ready=1.
- On that edge, go to IDLE.
REQ-018 in_ready SHALL be 0 in EXEC and RESP.
- in_valid and operand changes in EXEC or RESP SHALL be ignored.
- The latched operands SHALL be unaffected.
REQ-019 Timing from the accept edge N:
- out_valid rises after edge N+1.
- The earliest response handshake is edge N+2.
- The next request can be accepted at edge N+3 at the earliest (back-to-back rate: one request per 3 cycles).
REQ-020 On each completed response handshake:
- txn_count SHALL increment, with 255 wrapping to 0.
- err_count SHALL increment if err=1, holding at 255.
REQ-021 out_ready=1 outside RESP SHALL have no effect.
REQ-022 result and err SHALL keep their last values after the handshake until the next EXEC overwrites them.

Reset
REQ-023 rst_n=0 SHALL immediately, without waiting for a clock edge, set:
- state to IDLE;
- in_ready=1 and out_valid=0;
- result=0000 and err=0;
- txn_count=0 and err_count=0;
- the operand registers to 0.
REQ-024 Reset asserted during EXEC or RESP SHALL abort the transaction with no count update.
REQ-025 After rst_n rises, the first accept SHALL occur on the first rising edge with in_valid=1.

Verification
REQ-026 All cases run with A=1100, B=0110, C=0010, D=1100 and out_ready=1; required results:
- op0 -> 0010; op1 -> 0000; op2 -> 0001.
- op3 -> 0001; op4 -> 0100; op5 -> 0000.
- op6 -> 0001; op7 -> 0010; op8 -> 1100.
- err=0 throughout; txn_count=9 at the end.
REQ-027 Backpressure:
- Stimulus: op0 accepted; out_ready held 0 for 5 cycles; in_valid toggled and operands changed meanwhile.
- Response: out_valid stays 1; result stays 0010; in_ready stays 0; the response completes on the first edge with out_ready=1.
REQ-028 Illegal ops:
- Stimulus: ops 9 and 15.
- Response: result=0000, err=1; err_count=2; txn_count advances by 2.
REQ-029 Boundaries:
- A=1111, B=0001, op0 -> 0000.
- C=0100, op1 -> 0000.
- C=0000, op8 -> B.
- 256 completed responses -> txn_count=0.
- 260 illegal ops -> err_count=255.
REQ-030 Reset mid-operation:
- Stimulus: rst_n pulled low during RESP, between clock edges.
- Response: out_valid=0 and in_ready=1 immediately, without waiting for an edge; counts are 0; the next request after release is answered correctly.
